srdl2sv_amba3ahblite_pb: RTL

Parametrised AHB-Lite slave bridge between a system AHB-Lite fabric and the srdl2sv register interface (b2r/r2b), succeeding the single-outstanding bridge. Adds configurable bus and address width, a posted-write buffer for zero-wait writes, read-after-write ordering, a transfer timeout, and proper HREADY qualification. It sits between the interconnect and the generated register block.

---
 rtl/srdl2sv_amba3ahblite_pb.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/srdl2sv_amba3ahblite_pb.sv
// srdl2sv_amba3ahblite_pb: AHB-Lite slave to srdl2sv b2r/r2b bridge with posted-write buffer,
// read-after-write ordering, transfer timeout and HREADY-qualified address phases.
package srdl2sv_amba3ahblite_pb_pkg;
    // Struct fields are sized for the widest legal configuration; narrower buses zero-fill the top.
    typedef struct packed {
        logic        w_vld;
        logic        r_vld;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  byte_en;
    } b2r_t;

    typedef struct packed {
        logic [63:0] data;
        logic        rdy;
        logic        err;
    } r2b_t;
endpackage

module srdl2sv_amba3ahblite_pb
    import srdl2sv_amba3ahblite_pb_pkg::*;
#(
    parameter int BUS_BITS       = 32,
    parameter int ADDR_BITS      = 32,
    parameter int WBUF_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                            HCLK,
    input  logic                            HRESETn,
    input  logic                            HSEL,
    input  logic [ADDR_BITS-1:0]            HADDR,
    input  logic                            HWRITE,
    input  logic [2:0]                      HSIZE,
    input  logic [3:0]                      HPROT,
    input  logic [1:0]                      HTRANS,
    input  logic                            HREADY,
    input  logic [BUS_BITS-1:0]             HWDATA,
    output logic                            HREADYOUT,
    output logic                            HRESP,
    output logic [BUS_BITS-1:0]             HRDATA,
    output b2r_t                            b2r,
    input  r2b_t                            r2b,
    output logic [$clog2(WBUF_DEPTH):0]     wbuf_level,
    output logic                            posted_err
);
    localparam int BUS_BYTES = BUS_BITS / 8;
    localparam int BW        = $clog2(BUS_BYTES);
    localparam int PW        = WBUF_DEPTH > 1 ? $clog2(WBUF_DEPTH) : 1;
    localparam int LW        = $clog2(WBUF_DEPTH) + 1;

    typedef enum logic [2:0] {D_IDLE, D_WR, D_RD, D_ERR0, D_ERR1} state_t;

    state_t               state_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [BUS_BYTES-1:0] be_q;
    logic [BW-1:0]        off_q;
    logic [ADDR_BITS-1:0] wb_addr_q [WBUF_DEPTH];
    logic [BUS_BITS-1:0]  wb_data_q [WBUF_DEPTH];
    logic [BUS_BYTES-1:0] wb_be_q   [WBUF_DEPTH];
    logic [PW-1:0]        wp_q, rp_q;
    logic [LW-1:0]        lvl_q;
    logic [31:0]          tmo_q;
    logic                 perr_q;

    logic                 acc, ill, empty, full, rd_iss, w_vld, vld, fire, pop, push, hrdy;
    logic [BW-1:0]        mask;
    logic [BUS_BYTES-1:0] be_c;
    state_t               nxt;
    logic                 unused;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(WBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign acc  = HSEL && HREADY && HTRANS[1];
    assign mask = BW'((32'd1 << HSIZE) - 32'd1);
    assign ill  = (HSIZE > 3'(BW)) || |(HADDR[BW-1:0] & mask);
    assign be_c = BUS_BYTES'(((16'd1 << (5'd1 << HSIZE)) - 16'd1) << HADDR[BW-1:0]);
    assign nxt  = ill ? D_ERR0 : HWRITE ? D_WR : D_RD;

    // A read only issues once every earlier posted write has drained, so the two vlds never overlap.
    assign empty  = lvl_q == '0;
    assign full   = lvl_q == LW'(WBUF_DEPTH);
    assign rd_iss = (state_q == D_RD) && empty;
    assign w_vld  = !empty;
    assign vld    = w_vld || rd_iss;
    assign fire   = (TIMEOUT_CYCLES != 0) && vld && !r2b.rdy && (tmo_q == 32'(TIMEOUT_CYCLES - 1));
    assign pop    = w_vld && (r2b.rdy || r2b.err || fire);
    assign hrdy   = (state_q == D_WR) ? (!full || pop) :
                    (state_q == D_RD) ? (rd_iss && r2b.rdy && !r2b.err) :
                    (state_q != D_ERR0);
    assign push   = (state_q == D_WR) && hrdy;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= D_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            off_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            lvl_q   <= '0;
            tmo_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            if (state_q == D_ERR0)
                state_q <= D_ERR1;
            else if (rd_iss && ((r2b.rdy && r2b.err) || fire))
                state_q <= D_ERR0;
            else if (hrdy)
                state_q <= acc ? nxt : D_IDLE;
            if (hrdy && acc) begin
                addr_q <= {HADDR[ADDR_BITS-1:BW], BW'(0)};
                be_q   <= be_c;
                off_q  <= HADDR[BW-1:0];
            end
            if (push)
                wp_q <= inc(wp_q);
            if (pop)
                rp_q <= inc(rp_q);
            lvl_q  <= lvl_q + LW'(push) - LW'(pop);
            tmo_q  <= (vld && !r2b.rdy && !pop && !fire) ? tmo_q + 32'd1 : '0;
            perr_q <= w_vld && (r2b.err || fire);
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) begin
            wb_addr_q[wp_q] <= addr_q;
            wb_data_q[wp_q] <= HWDATA << {off_q, 3'b000};
            wb_be_q[wp_q]   <= be_q;
        end
    end

    always_comb begin
        b2r         = '0;
        b2r.w_vld   = w_vld;
        b2r.r_vld   = rd_iss;
        b2r.addr    = w_vld ? 32'(wb_addr_q[rp_q]) : rd_iss ? 32'(addr_q) : '0;
        b2r.data    = w_vld ? 64'(wb_data_q[rp_q]) : '0;
        b2r.byte_en = w_vld ? 8'(wb_be_q[rp_q]) : rd_iss ? 8'(be_q) : '0;
    end

    assign HREADYOUT  = hrdy;
    assign HRESP      = (state_q == D_ERR0) || (state_q == D_ERR1);
    assign HRDATA     = rd_iss ? r2b.data[BUS_BITS-1:0] : '0;
    assign wbuf_level = lvl_q;
    assign posted_err = perr_q;
    assign unused     = ^{HPROT, HTRANS[0], r2b.data};
endmodule
